// File: rtl/issue_queue_if.sv
// Dispatcher / writeback / functional-unit signals of one issue queue.
// The queue is the slave; the dispatcher-side driver is the master.
interface issue_queue_if #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 64,
  parameter int TAG_W  = 6
);
  localparam int CW = $clog2(DEPTH + 1);

  logic              enq;
  logic [DATA_W-1:0] data_in;
  logic [TAG_W-1:0]  src1_tag;
  logic              src1_rdy;
  logic [TAG_W-1:0]  src2_tag;
  logic              src2_rdy;
  logic              full;
  logic [CW-1:0]     count;
  logic              wb_valid;
  logic [TAG_W-1:0]  wb_tag;
  logic              flush;
  logic              issue_valid;
  logic [DATA_W-1:0] issue_data;
  logic              issue_ready;

  modport master (
    output enq, data_in, src1_tag, src1_rdy,
    output src2_tag, src2_rdy,
    output wb_valid, wb_tag, flush, issue_ready,
    input  full, count, issue_valid, issue_data
  );

  modport slave (
    input  enq, data_in, src1_tag, src1_rdy,
    input  src2_tag, src2_rdy,
    input  wb_valid, wb_tag, flush, issue_ready,
    output full, count, issue_valid, issue_data
  );
endinterface

// File: rtl/issue_queue.sv
// Compacting age-ordered issue queue: index 0 is oldest,
// oldest ready entry issues, younger entries shift down.
module issue_queue #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 64,
  parameter int TAG_W  = 6
) (
  input logic         clk,
  input logic         resetn,
  issue_queue_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(DEPTH);

  logic [CW-1:0]     cnt, n_cnt, widx;
  logic [DATA_W-1:0] pay [DEPTH];
  logic [DATA_W-1:0] n_pay [DEPTH];
  logic [TAG_W-1:0]  t1 [DEPTH];
  logic [TAG_W-1:0]  t2 [DEPTH];
  logic [TAG_W-1:0]  n_t1 [DEPTH];
  logic [TAG_W-1:0]  n_t2 [DEPTH];
  logic [DEPTH-1:0]  r1, r2, n_r1, n_r2, vld;
  logic [IW-1:0]     sel;
  logic              found, fire, acc;
  logic              byp1, byp2;

  always_comb begin
    vld = '0;
    for (int i = 0; i < DEPTH; i++)
      vld[i] = (i < int'(cnt));
  end

  // Scan from the top so the lowest ready index wins.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (vld[i] && r1[i] && r2[i]) begin
        found = 1'b1;
        sel   = IW'(i);
      end
    end
  end

  assign bus.full        = (cnt == CW'(DEPTH));
  assign bus.count       = cnt;
  assign bus.issue_valid = found;
  assign bus.issue_data  = pay[sel];

  assign fire = found && bus.issue_ready;
  assign acc  = bus.enq && !bus.full;
  assign widx = fire ? cnt - CW'(1) : cnt;
  assign byp1 = bus.src1_rdy ||
    (bus.wb_valid && bus.wb_tag == bus.src1_tag);
  assign byp2 = bus.src2_rdy ||
    (bus.wb_valid && bus.wb_tag == bus.src2_tag);

  always_comb begin
    int src;
    src   = 0;
    n_r1  = '0;
    n_r2  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      src = i;
      if (fire && i >= int'(sel) && i < DEPTH - 1)
        src = i + 1;
      n_pay[i] = pay[src];
      n_t1[i]  = t1[src];
      n_t2[i]  = t2[src];
      n_r1[i]  = r1[src] ||
        (bus.wb_valid && bus.wb_tag == t1[src]);
      n_r2[i]  = r2[src] ||
        (bus.wb_valid && bus.wb_tag == t2[src]);
      if (acc && i == int'(widx)) begin
        n_pay[i] = bus.data_in;
        n_t1[i]  = bus.src1_tag;
        n_t2[i]  = bus.src2_tag;
        n_r1[i]  = byp1;
        n_r2[i]  = byp2;
      end
    end
    n_cnt = cnt + CW'(acc) - CW'(fire);
  end

  always_ff @(posedge clk) begin
    if (resetn || bus.flush) begin
      cnt <= '0;
    end else begin
      cnt <= n_cnt;
      pay <= n_pay;
      t1  <= n_t1;
      t2  <= n_t2;
      r1  <= n_r1;
      r2  <= n_r2;
    end
  end
endmodule

// File: tb/tb_issue_queue.sv
// Bench for issue_queue: directed scenarios then random traffic,
// checked each cycle against a queue-based reference model.
module tb_issue_queue;
  localparam int DEPTH  = 8;
  localparam int DATA_W = 64;
  localparam int TAG_W  = 6;
  localparam int CW     = $clog2(DEPTH + 1);

  typedef struct {
    logic [DATA_W-1:0] d;
    logic [TAG_W-1:0]  t1;
    bit                r1;
    logic [TAG_W-1:0]  t2;
    bit                r2;
  } ent_t;

  logic clk = 1'b0;
  logic resetn;
  int   checks = 0;
  int   errors = 0;
  bit   chk = 0;
  ent_t q[$];

  issue_queue_if #(.DEPTH(DEPTH), .DATA_W(DATA_W), .TAG_W(TAG_W)) bus ();

  issue_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W), .TAG_W(TAG_W)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic step(
    input bit e, input logic [DATA_W-1:0] d,
    input logic [TAG_W-1:0] a, input bit ar,
    input logic [TAG_W-1:0] b, input bit br,
    input bit wv, input logic [TAG_W-1:0] wt,
    input bit rdy, input bit fl, input bit rs
  );
    bit   exp_iv;
    int   idx;
    ent_t n;
    @(negedge clk);
    exp_iv = 0;
    idx = -1;
    foreach (q[i])
      if (idx < 0 && q[i].r1 && q[i].r2) idx = i;
    exp_iv = (idx >= 0);
    if (chk) begin
      checks++;
      assert (bus.count === CW'(q.size())) else begin
        errors++;
        $error("FAIL count got %0d exp %0d", bus.count, q.size());
      end
      checks++;
      assert (bus.full === (q.size() == DEPTH)) else begin
        errors++;
        $error("FAIL full got %b exp %b", bus.full, q.size() == DEPTH);
      end
      checks++;
      assert (bus.issue_valid === exp_iv) else begin
        errors++;
        $error("FAIL issue_valid got %b exp %b", bus.issue_valid, exp_iv);
      end
      if (exp_iv) begin
        checks++;
        assert (bus.issue_data === q[idx].d) else begin
          errors++;
          $error("FAIL issue_data got %h exp %h", bus.issue_data, q[idx].d);
        end
      end
    end
    resetn          = rs;
    bus.enq         = e;
    bus.data_in     = d;
    bus.src1_tag    = a;
    bus.src1_rdy    = ar;
    bus.src2_tag    = b;
    bus.src2_rdy    = br;
    bus.wb_valid    = wv;
    bus.wb_tag      = wt;
    bus.issue_ready = rdy;
    bus.flush       = fl;
    if (rs || fl) begin
      q.delete();
    end else begin
      bit accept;
      accept = e && q.size() < DEPTH;
      foreach (q[i]) begin
        if (wv && wt == q[i].t1) q[i].r1 = 1;
        if (wv && wt == q[i].t2) q[i].r2 = 1;
      end
      if (exp_iv && rdy) q.delete(idx);
      if (accept) begin
        n.d  = d;
        n.t1 = a;
        n.r1 = ar || (wv && wt == a);
        n.t2 = b;
        n.r2 = br || (wv && wt == b);
        q.push_back(n);
      end
    end
    chk = 1;
  endtask

  task automatic idle(input bit rdy);
    step(0, '0, 0, 0, 0, 0, 0, 0, rdy, 0, 0);
  endtask

  task automatic put(input logic [DATA_W-1:0] d, input logic [TAG_W-1:0] a,
                     input bit ar, input bit rdy);
    step(1, d, a, ar, 6'd62, 1, 0, 0, rdy, 0, 0);
  endtask

  initial begin
    step(0, '0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step(0, '0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    // in-order issue of ready entries
    put(64'hA, 1, 1, 1);
    put(64'hB, 1, 1, 1);
    put(64'hC, 1, 1, 1);
    repeat (4) idle(1);
    // younger ready entry bypasses older waiting one
    put(64'h1, 5, 0, 1);
    put(64'h2, 1, 1, 1);
    idle(1);
    step(0, '0, 0, 0, 0, 0, 1, 5, 1, 0, 0);
    repeat (3) idle(1);
    // fill to full; enq while full, also alongside an issue
    for (int i = 0; i < DEPTH; i++) put(64'h100 + i, 20 + i, 0, 0);
    idle(0);
    put(64'h1FF, 1, 1, 0);
    checks++;
    assert (bus.count === CW'(DEPTH)) else begin
      errors++;
      $error("FAIL full_count got %0d exp %0d", bus.count, DEPTH);
    end
    step(0, '0, 0, 0, 0, 0, 1, 20, 0, 0, 0);
    put(64'h1FE, 1, 1, 1);
    idle(0);
    idle(0);
    step(0, '0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    // same-cycle wakeup bypass on src2
    step(1, 64'hB7, 1, 1, 9, 0, 1, 9, 1, 0, 0);
    repeat (2) idle(1);
    // issue from index 1 together with an enqueue
    put(64'h50, 30, 0, 0);
    put(64'h51, 1, 1, 0);
    put(64'h52, 31, 0, 0);
    put(64'h53, 32, 0, 0);
    put(64'h54, 1, 1, 1);
    idle(0);
    step(0, '0, 0, 0, 0, 0, 1, 30, 0, 0, 0);
    step(0, '0, 0, 0, 0, 0, 1, 31, 0, 0, 0);
    step(0, '0, 0, 0, 0, 0, 1, 32, 0, 0, 0);
    repeat (6) idle(1);
    // flush, then reset, with an enq in flight
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 5; i++) put(64'h60 + i, 1, 1, 0);
      idle(0);
      step(1, 64'h6F, 1, 1, 1, 1, 0, 0, 1, k == 0, k == 1);
      idle(1);
      idle(1);
    end
    // random traffic
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 9) < 6, {$urandom, $urandom},
           TAG_W'($urandom_range(0, 7)), $urandom_range(0, 2) == 0,
           TAG_W'($urandom_range(0, 7)), $urandom_range(0, 2) == 0,
           $urandom_range(0, 1) == 1, TAG_W'($urandom_range(0, 7)),
           $urandom_range(0, 9) < 6,
           $urandom_range(0, 59) == 0, $urandom_range(0, 99) == 0);
    end
    idle(0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/issue_queue.md
Name: issue_queue

Overview:
- Receiving end of the dispatcher-to-issue-queue interface. One instance each for the integer ALU, FP ALU and AGU paths.
- Accepts dispatched micro-ops via `enq` and back-pressures the dispatcher via `full`.
- Tracks source-operand readiness using writeback tag broadcasts.
- Issues the oldest ready entry to its functional unit over a valid/ready handshake.

Parameters:
- DEPTH, 8: number of entries; integer ≥ 2.
- DATA_W, 64: micro-op payload width (opcode, immediates, destination tag), carried opaquely.
- TAG_W, 6: physical register tag width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- resetn  in  1  synchronous reset, active-high: asserted = 1 despite the name.
- enq  in  1  dispatcher enqueue strobe.
- data_in  in  DATA_W  payload for the enqueued micro-op.
- src1_tag  in  TAG_W  tag of source operand 1.
- src1_rdy  in  1  source 1 already available at dispatch.
- src2_tag  in  TAG_W  tag of source operand 2.
- src2_rdy  in  1  source 2 already available at dispatch.
- full  out  1  no free entry; dispatcher must not assert `enq`.
- count  out  $clog2(DEPTH+1)  number of valid entries.
- wb_valid  in  1  writeback broadcast valid.
- wb_tag  in  TAG_W  tag being written back.
- flush  in  1  discard all entries (mispredict/exception).
- issue_valid  out  1  an issuable entry is presented.
- issue_data  out  DATA_W  payload of the presented entry.
- issue_ready  in  1  functional unit accepts this cycle.

Behaviour:
- **Storage.** Compacting array; index 0 is the oldest entry.
  - Per-entry state: valid, payload, src1_tag, r1, src2_tag, r2.
  - Valid entries are always contiguous from index 0, so `count` equals the number of valid entries.
- **Reset** (`resetn` = 1 at edge): all valid bits cleared; `count` = 0, `full` = 0, `issue_valid` = 0. `issue_data` is don't-care while `issue_valid` = 0.
- **Flush** (`flush` = 1 at edge, no reset): same result as reset. Flush takes priority over enq, issue and wakeup in that cycle. Reset has priority over flush.
- **full / count.**
  - `full` = (`count` == DEPTH), decoded from registered `count` only.
  - `full` does not fall in the same cycle as an issue; it falls the cycle after.
- **Enqueue.**
  - Accepted when `enq` = 1 and `full` = 0.
  - `enq` while `full` = 1 is ignored: no state change. This holds even if an issue happens the same cycle.
  - The new entry is written at index `count`, or `count` − 1 when an issue also happens that cycle.
  - Stored r1 = `src1_rdy` OR (`wb_valid` AND `wb_tag` == `src1_tag`); r2 likewise. This is the same-cycle wakeup bypass.
- **Wakeup.**
  - Each cycle, every valid entry whose `src1_tag` == `wb_tag` while `wb_valid` = 1 sets r1 at the edge; likewise r2.
  - Ready bits never clear except by reset, flush or issue.
  - Wakeup affects selection starting the next cycle.
- **Selection** (combinational from registered state):
  - Selected entry = lowest-index valid entry with r1 AND r2.
  - `issue_valid` = 1 iff one exists; `issue_data` = its payload.
  - An entry enqueued at edge N can be selected at cycle N+1 at the earliest. Minimum enq-to-issue latency is 1 cycle.
- **Issue.**
  - Handshake completes when `issue_valid` AND `issue_ready` are both 1.
  - The selected entry is removed and all higher-index entries shift down by one, preserving age order.
  - `count` decrements, or holds if an enqueue is also accepted.
  - With `issue_valid` = 0, `issue_ready` has no effect.
  - `issue_data` stays stable while `issue_valid` = 1 and `issue_ready` = 0. An older entry becoming ready may change the selection only at the next edge, by wakeup.
- **Limits.** At most one enqueue and one issue per cycle. `count` never exceeds DEPTH and never underflows.

Test Plan:
1. Reset, then enq 3 entries all ready (payloads 0xA, 0xB, 0xC), `issue_ready` = 1 → issued in order A, B, C on consecutive cycles starting 1 cycle after first enq; `count` returns to 0.
2. Enq entry P1 (src1 tag 5 not ready), then P2 (both ready); `issue_ready` = 1 → P2 issues first. Broadcast `wb_tag` = 5 → P1 issues the cycle after the broadcast.
3. Fill 8 entries, none ready → `full` = 1 and `count` = 8. A 9th enq is ignored (`count` stays 8). Wakeup and issue one → `full` = 0 the following cycle.
4. Enq with `src2_tag` = 9, `src2_rdy` = 0 in the same cycle as `wb_valid` = 1, `wb_tag` = 9 (src1 ready) → entry issues the next cycle (bypass).
5. `count` = 4, simultaneous issue of index 1 and enq of X → `count` stays 4; order is idx0, old idx2, old idx3, X.
6. `count` = 5 with `issue_valid` = 1: assert flush together with enq → `count` = 0 and `issue_valid` = 0 next cycle; the enq is dropped. Repeat with `resetn` mid-stream → same.
